// File: rtl/fas_pkg.sv
// Shared constants and types for the floating-point add/subtract pipeline.
package fas_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_INF    = 255;

    localparam int SIG_CARRY  = 31;
    localparam int SIG_HIDDEN = 30;
    localparam int FRAC_MSB   = 29;
    localparam int FRAC_LSB   = 7;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [7:0]  FP_INF_EXP  = 8'hFF;

    // Stage A register contents: operand plus its classification.
    typedef struct packed {
        logic        sign;
        logic [31:0] sig;
        logic [8:0]  base_e;
        logic [4:0]  lz;
        logic        z;
    } stage_a_t;

endpackage

// File: rtl/fas_pipline4_if.sv
// Operand/result bundle for the normalize-and-pack stage.
interface fas_pipline4_if;
    import fas_pkg::*;

    logic [32:0] x3;
    logic [8:0]  base_ei;
    logic        enable;
    logic [31:0] result;
    logic        valid;
    logic        ovf;
    logic        unf;
    logic        zero;

    modport master (
        output x3, base_ei, enable,
        input  result, valid, ovf, unf, zero
    );

    modport slave (
        input  x3, base_ei, enable,
        output result, valid, ovf, unf, zero
    );

endinterface

// File: rtl/fas_lzc31.sv
// Leading-zero counter over a 31-bit vector; all-zero input yields 31.
module fas_lzc31 (
    input  logic [30:0] din,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        count = 5'd31;
        for (int unsigned i = 0; i < 31; i++) begin
            if (din[i]) count = 5'(30 - i);
        end
    end

endmodule

// File: rtl/fas_pipline4.sv
// Stage 4 of the FP add/subtract pipeline: normalize, range-check and pack.
// Sub-stage A counts leading zeros and classifies, sub-stage B shifts and packs.
module fas_pipline4
    import fas_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fas_pipline4_if.slave io
);

    stage_a_t          a_q;
    logic              valid_a;
    logic [4:0]        lz_in;

    logic signed [10:0] e;
    logic [30:0]       n;
    logic [22:0]       frac;
    logic [31:0]       res_d;
    logic              ovf_d;
    logic              unf_d;
    logic              zero_d;
    logic              unused_bits;

    fas_lzc31 u_lzc (
        .din   (io.x3[SIG_HIDDEN:0]),
        .count (lz_in)
    );

    // Stage A: capture the operand and its leading-zero classification.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            valid_a <= 1'b0;
        end else begin
            valid_a <= io.enable;
            if (io.enable) begin
                a_q.sign   <= io.x3[32];
                a_q.sig    <= io.x3[31:0];
                a_q.base_e <= io.base_ei;
                a_q.lz     <= lz_in;
                a_q.z      <= (io.x3[31:0] == '0);
            end
        end
    end

    // Stage B combinational: normalize, adjust exponent, pick output class.
    always_comb begin
        n      = a_q.sig[SIG_HIDDEN:0] << a_q.lz;
        e      = '0;
        frac   = '0;
        res_d  = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;

        if (a_q.sig[SIG_CARRY]) begin
            e    = $signed({{2{a_q.base_e[8]}}, a_q.base_e}) + 11'sd1;
            frac = a_q.sig[SIG_HIDDEN:FRAC_LSB+1];
        end else begin
            e    = $signed({{2{a_q.base_e[8]}}, a_q.base_e}) - $signed({6'b0, a_q.lz});
            frac = n[FRAC_MSB:FRAC_LSB];
        end

        if (a_q.z) begin
            res_d  = FP_POS_ZERO;
            zero_d = 1'b1;
        end else if (int'(e) >= EXP_INF) begin
            res_d  = {a_q.sign, FP_INF_EXP, 23'h0};
            ovf_d  = 1'b1;
        end else if (int'(e) <= 0) begin
            res_d  = {a_q.sign, 31'h0};
            unf_d  = 1'b1;
        end else begin
            res_d  = {a_q.sign, e[7:0], frac};
        end
    end

    // Bits of the shifted significand outside the fraction field are discarded.
    assign unused_bits = ^{n[SIG_HIDDEN], n[FRAC_LSB-1:0]};

    // Stage B register: result and flags update only for a valid stage-A entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            io.result <= '0;
            io.ovf    <= 1'b0;
            io.unf    <= 1'b0;
            io.zero   <= 1'b0;
            io.valid  <= 1'b0;
        end else begin
            io.valid <= valid_a;
            if (valid_a) begin
                io.result <= res_d;
                io.ovf    <= ovf_d;
                io.unf    <= unf_d;
                io.zero   <= zero_d;
            end
        end
    end

endmodule

// File: tb/tb_fas_pipline4.sv
// Self-checking bench for fas_pipline4: directed literal vectors, random
// streaming with bubbles, and a mid-flight reset, checked against a
// value-level model every cycle.
module tb_fas_pipline4;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    fas_pipline4_if io ();

    fas_pipline4 dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    // Returns {ovf, unf, zero, result} from plain arithmetic on the value.
    function automatic logic [34:0] model(input logic [32:0] x, input logic [8:0] be);
        logic        s;
        logic [31:0] sig;
        int          p;
        int          e;
        longint      v;
        s   = x[32];
        sig = x[31:0];
        if (sig == 32'h0) return {3'b001, 32'h0};
        p = 31;
        while (!sig[p]) p--;
        e = int'($signed(be)) + p - 30;
        if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
        if (e <= 0)   return {3'b010, s, 31'h0};
        v = longint'(sig);
        if (p <= 23) v = v << (23 - p);
        else         v = v >> (p - 23);
        return {3'b000, s, 8'(e), v[22:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference pipeline state, advanced on each rising edge.
    logic        s1_v  = 1'b0;
    logic [34:0] s1_o  = '0;
    logic        out_v = 1'b0;
    logic [34:0] held  = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                s1_v  = 1'b0;
                out_v = 1'b0;
                held  = '0;
            end else begin
                out_v = s1_v;
                if (s1_v) held = s1_o;
                s1_v = io.enable;
                if (io.enable) s1_o = model(io.x3, io.base_ei);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("valid", 64'(io.valid), 64'(out_v));
            chk("out", 64'({io.ovf, io.unf, io.zero, io.result}), 64'(held));
        end
    end

    typedef struct {
        logic [32:0] x;
        logic [8:0]  b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs [10] = '{
        '{ {1'b0, 32'h4000_0000}, 9'd127, 32'h3F80_0000, 3'b000 },
        '{ {1'b1, 32'h8000_0000}, 9'd127, 32'hC000_0000, 3'b000 },
        '{ {1'b0, 32'h0000_0080}, 9'd127, 32'h3400_0000, 3'b000 },
        '{ {1'b1, 32'h0000_0000}, 9'd55,  32'h0000_0000, 3'b001 },
        '{ {1'b0, 32'h8000_0000}, 9'd254, 32'h7F80_0000, 3'b100 },
        '{ {1'b0, 32'h0000_0080}, 9'd10,  32'h0000_0000, 3'b010 },
        '{ {1'b0, 32'h0000_0001}, 9'd157, 32'h3F80_0000, 3'b000 },
        '{ {1'b1, 32'h4000_0000}, 9'd0,   32'h8000_0000, 3'b010 },
        '{ {1'b0, 32'h4000_0000}, 9'd1,   32'h0080_0000, 3'b000 },
        '{ {1'b0, 32'hFFFF_FFFF}, 9'd100, 32'h32FF_FFFF, 3'b000 }
    };

    // Called one tick after a rising edge; returns on the falling edge
    // after the result should have landed.
    task automatic run_vec(input vec_t v);
        io.x3      = v.x;
        io.base_ei = v.b;
        io.enable  = 1'b1;
        chk("model_pin", 64'(model(v.x, v.b)), 64'({v.f, v.r}));
        @(posedge clk);
        #1 io.enable = 1'b0;
        @(negedge clk);
        chk("valid_early", 64'(io.valid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("vec_valid", 64'(io.valid), 64'(1));
        chk("vec_result", 64'(io.result), 64'(v.r));
        chk("vec_flags", 64'({io.ovf, io.unf, io.zero}), 64'(v.f));
    endtask

    task automatic drive_rand();
        io.x3      = {1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 31)};
        io.base_ei = 9'($urandom_range(0, 511));
        io.enable  = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        io.enable  = 1'b0;
        io.x3      = '0;
        io.base_ei = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(io.valid), 64'(0));
        chk("reset_result", 64'(io.result), 64'(0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 run_vec(vecs[i]);
        end

        // Back-to-back random stream, then enable = 1,0,1.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            @(posedge clk);
            #1;
        end
        drive_rand();
        @(posedge clk);
        #1 io.enable = 1'b0;
        @(posedge clk);
        #1 drive_rand();
        @(posedge clk);
        #1 io.enable = 1'b0;
        repeat (4) @(posedge clk);

        // Reset while one op sits in stage A and another is being presented.
        #1 io.x3 = {1'b0, 32'h4000_0000};
        io.base_ei = 9'd130;
        io.enable  = 1'b1;
        @(posedge clk);
        #1 io.x3 = {1'b1, 32'h8000_0000};
        io.base_ei = 9'd20;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        io.enable = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(io.valid), 64'(0));
        chk("rst_result", 64'(io.result), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_emerge", 64'({io.valid, io.result}), 64'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
